// File: rtl/sim_halt_monitor.sv
// rtl/sim_halt_monitor.sv - run-control monitor: halt-trap detection, watchdog, counters and PC history
module sim_halt_monitor #(
    parameter int          CNT_W          = 32,
    parameter logic [5:0]  TRAP_OPCODE    = 6'h11,
    parameter logic [25:0] HALT_IMM       = 26'h300,
    parameter int          DRAIN_CYCLES   = 0,
    parameter int          TIMEOUT_CYCLES = 2500,
    parameter int          HIST_DEPTH     = 4,
    localparam int         IDX_W          = $clog2(HIST_DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [0:31]      instr,
    input  logic [0:31]      pc,
    input  logic [IDX_W-1:0] hist_idx,
    output logic [0:31]      hist_pc,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count,
    output logic [CNT_W-1:0] trap_count,
    output logic             halted,
    output logic             timed_out,
    output logic             done
);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, HALTED, TIMEOUT} state_t;

    state_t           state;
    logic [0:31]      hist [HIST_DEPTH];
    logic [IDX_W-1:0] wptr;
    logic [IDX_W-1:0] rptr;
    logic [31:0]      drain_cnt;

    logic             active;
    logic             decode;
    logic             is_trap;
    logic             is_halt;
    logic             wd_hit;
    logic [CNT_W-1:0] cycle_next;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The instruction that wakes the monitor from IDLE is treated exactly like a RUN retire.
    assign active     = (state == RUN) || (state == DRAIN) || ((state == IDLE) && instr_valid);
    assign decode     = instr_valid && ((state == IDLE) || (state == RUN));
    assign is_trap    = (instr[0:5] == TRAP_OPCODE);
    assign is_halt    = is_trap && (instr[6:31] == HALT_IMM);
    assign cycle_next = sat_inc(cycle_count);
    assign wd_hit     = (TIMEOUT_CYCLES != 0) && (cycle_next >= CNT_W'(TIMEOUT_CYCLES));

    assign rptr    = wptr - IDX_W'(1) - hist_idx;
    assign hist_pc = hist[rptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cycle_count <= '0;
            instr_count <= '0;
            trap_count  <= '0;
            halted      <= 1'b0;
            timed_out   <= 1'b0;
            done        <= 1'b0;
            wptr        <= '0;
            drain_cnt   <= '0;
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else begin
            if (active) begin
                cycle_count <= cycle_next;
                if (instr_valid) begin
                    instr_count <= sat_inc(instr_count);
                    hist[wptr]  <= pc;
                    wptr        <= wptr + IDX_W'(1);
                end
            end

            case (state)
                IDLE, RUN: begin
                    if ((state == RUN) || instr_valid) begin
                        // Halt trap takes priority over a watchdog expiry on the same clock.
                        if (decode && is_halt) begin
                            if (DRAIN_CYCLES == 0) begin
                                state  <= HALTED;
                                halted <= 1'b1;
                                done   <= 1'b1;
                            end else begin
                                state     <= DRAIN;
                                drain_cnt <= '0;
                            end
                        end else begin
                            if (decode && is_trap) begin
                                trap_count <= sat_inc(trap_count);
                            end
                            if (wd_hit) begin
                                state     <= TIMEOUT;
                                timed_out <= 1'b1;
                                done      <= 1'b1;
                            end else begin
                                state <= RUN;
                            end
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 32'(DRAIN_CYCLES - 1)) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                        done   <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sim_halt_monitor.sv
// tb/tb_sim_halt_monitor.sv - scoreboard bench for sim_halt_monitor (three parameter sets)
module tb_sim_halt_monitor;

    localparam logic [31:0] ADD  = 32'h7C00_0214;
    localparam logic [31:0] HALT = 32'h4400_0300;
    localparam logic [31:0] TRAP = 32'h4400_0004;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic [0:31] instr = '0;
    logic [0:31] pc = '0;
    logic [1:0]  hist_idx = '0;

    logic [0:31] hpc_o [3];
    logic [31:0] cyc_o [3];
    logic [31:0] ins_o [3];
    logic [31:0] trp_o [3];
    logic        hlt_o [3];
    logic        tmo_o [3];
    logic        done_o [3];

    always #5 clock = ~clock;

    sim_halt_monitor u0 (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr), .pc(pc),
        .hist_idx(hist_idx), .hist_pc(hpc_o[0]), .cycle_count(cyc_o[0]), .instr_count(ins_o[0]),
        .trap_count(trp_o[0]), .halted(hlt_o[0]), .timed_out(tmo_o[0]), .done(done_o[0])
    );

    sim_halt_monitor #(.DRAIN_CYCLES(3)) u1 (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr), .pc(pc),
        .hist_idx(hist_idx), .hist_pc(hpc_o[1]), .cycle_count(cyc_o[1]), .instr_count(ins_o[1]),
        .trap_count(trp_o[1]), .halted(hlt_o[1]), .timed_out(tmo_o[1]), .done(done_o[1])
    );

    sim_halt_monitor #(.TIMEOUT_CYCLES(10)) u2 (
        .clock(clock), .reset(reset), .instr_valid(instr_valid), .instr(instr), .pc(pc),
        .hist_idx(hist_idx), .hist_pc(hpc_o[2]), .cycle_count(cyc_o[2]), .instr_count(ins_o[2]),
        .trap_count(trp_o[2]), .halted(hlt_o[2]), .timed_out(tmo_o[2]), .done(done_o[2])
    );

    typedef struct packed {
        logic [1:0]  dut;
        logic [31:0] cyc;
        logic [31:0] ins;
        logic [31:0] trp;
        logic        hlt;
        logic        tmo;
    } exp_t;

    exp_t exp_q[$];
    logic done_prev [3] = '{1'b0, 1'b0, 1'b0};
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic expect_done(input int d, input int cyc, input int ins, input int trp,
                               input logic hlt, input logic tmo);
        exp_t e;
        e.dut = 2'(d);
        e.cyc = 32'(cyc);
        e.ins = 32'(ins);
        e.trp = 32'(trp);
        e.hlt = hlt;
        e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    // Completion monitor: every rising done must match the oldest expectation.
    always @(negedge clock) begin : mon
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            if (done_o[d] && !done_prev[d]) begin
                if (exp_q.size() == 0) begin
                    check($sformatf("unexpected_done_u%0d", d), 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_dut",    64'(d),        64'(e.dut));
                    check("sb_cycle",  64'(cyc_o[d]), 64'(e.cyc));
                    check("sb_instr",  64'(ins_o[d]), 64'(e.ins));
                    check("sb_trap",   64'(trp_o[d]), 64'(e.trp));
                    check("sb_halted", 64'(hlt_o[d]), 64'(e.hlt));
                    check("sb_tmo",    64'(tmo_o[d]), 64'(e.tmo));
                end
            end
            done_prev[d] = done_o[d];
        end
    end

    task automatic issue(input logic v, input logic [31:0] i, input logic [31:0] p);
        instr_valid = v;
        instr       = i;
        pc          = p;
        @(posedge clock);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(posedge clock);
            #1;
            n++;
        end
        check(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        #1;
        check("rst_cycle",  64'(cyc_o[0]),  64'd0);
        check("rst_instr",  64'(ins_o[0]),  64'd0);
        check("rst_trap",   64'(trp_o[0]),  64'd0);
        check("rst_halted", 64'(hlt_o[0]),  64'd0);
        check("rst_tmo",    64'(tmo_o[0]),  64'd0);
        check("rst_done",   64'(done_o[0]), 64'd0);
        for (int k = 0; k < 4; k++) begin
            hist_idx = 2'(k);
            #1;
            check("rst_hist", 64'(hpc_o[0]), 64'd0);
        end
        hist_idx = 2'd0;
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Basic halt (u0), drained halt (u1), halt before watchdog (u2)
        for (int k = 0; k < 5; k++) issue(1'b1, ADD, 32'(4 * k));
        expect_done(0, 6, 6, 0, 1'b1, 1'b0);
        expect_done(2, 6, 6, 0, 1'b1, 1'b0);
        expect_done(1, 9, 6, 0, 1'b1, 1'b0);
        issue(1'b1, HALT, 32'h14);
        check("t1_halt_latency", 64'(hlt_o[0]), 64'd1);
        check("t2_drain_start",  64'(hlt_o[1]), 64'd0);
        hist_idx = 2'd0;
        #1;
        check("t1_hist0", 64'(hpc_o[0]), 64'h14);
        hist_idx = 2'd3;
        #1;
        check("t1_hist3", 64'(hpc_o[0]), 64'h08);
        hist_idx = 2'd0;
        for (int k = 1; k <= 3; k++) begin
            issue(1'b0, 32'h0, 32'h0);
            if (k < 3) check("t2_drain_hold", 64'(hlt_o[1]), 64'd0);
            else       check("t2_halt_rise",  64'(hlt_o[1]), 64'd1);
        end
        check("t2_cycle", 64'(cyc_o[1]), 64'd9);
        wait_drain("t12_drain", 5);

        // Watchdog on an endless loop (u2)
        do_reset();
        expect_done(2, 10, 10, 0, 1'b0, 1'b1);
        for (int k = 0; k < 14; k++) begin
            issue(1'b1, ADD, 32'h100 + 32'(4 * (k % 3)));
            if (k == 8) check("t3_pre_timeout", 64'(tmo_o[2]), 64'd0);
            if (k == 9) check("t3_timeout_lat", 64'(tmo_o[2]), 64'd1);
        end
        check("t3_cycle_frozen", 64'(cyc_o[2]),  64'd10);
        check("t3_instr_frozen", 64'(ins_o[2]),  64'd10);
        check("t3_done",         64'(done_o[2]), 64'd1);
        check("t3_not_halted",   64'(hlt_o[2]),  64'd0);
        check("t3_u0_running",   64'(done_o[0]), 64'd0);
        wait_drain("t3_drain", 2);

        // Non-halt traps, plus traps/halts during drain that must not be re-decoded
        do_reset();
        expect_done(0, 3, 3, 2, 1'b1, 1'b0);
        expect_done(2, 3, 3, 2, 1'b1, 1'b0);
        expect_done(1, 6, 5, 2, 1'b1, 1'b0);
        issue(1'b1, TRAP, 32'h20);
        issue(1'b1, TRAP, 32'h24);
        issue(1'b1, HALT, 32'h28);
        issue(1'b1, TRAP, 32'h2C);
        issue(1'b1, HALT, 32'h30);
        issue(1'b0, 32'h0, 32'h0);
        check("t4_u0_trap",   64'(trp_o[0]), 64'd2);
        check("t4_u0_frozen", 64'(ins_o[0]), 64'd3);
        check("t4_u1_instr",  64'(ins_o[1]), 64'd5);
        check("t4_u1_hist0",  64'(hpc_o[1]), 64'h30);
        wait_drain("t4_drain", 4);

        // Halt retires on the watchdog cycle: halt wins (u2)
        do_reset();
        expect_done(0, 10, 10, 0, 1'b1, 1'b0);
        expect_done(2, 10, 10, 0, 1'b1, 1'b0);
        expect_done(1, 13, 10, 0, 1'b1, 1'b0);
        for (int k = 0; k < 9; k++) issue(1'b1, ADD, 32'(4 * k));
        issue(1'b1, HALT, 32'h24);
        check("t5_halted", 64'(hlt_o[2]), 64'd1);
        check("t5_no_tmo", 64'(tmo_o[2]), 64'd0);
        for (int k = 0; k < 3; k++) issue(1'b0, 32'h0, 32'h0);
        wait_drain("t5_drain", 3);

        // Asynchronous reset mid-run, then a fresh program
        do_reset();
        for (int k = 0; k < 3; k++) issue(1'b1, ADD, 32'(4 * k));
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_cycle", 64'(cyc_o[0]),  64'd0);
        check("t6_async_instr", 64'(ins_o[0]),  64'd0);
        check("t6_async_hist",  64'(hpc_o[0]),  64'd0);
        check("t6_async_done",  64'(done_o[0]), 64'd0);
        @(negedge clock);
        reset = 1'b0;
        expect_done(0, 2, 2, 0, 1'b1, 1'b0);
        expect_done(2, 2, 2, 0, 1'b1, 1'b0);
        expect_done(1, 5, 2, 0, 1'b1, 1'b0);
        issue(1'b1, ADD, 32'h40);
        check("t6_restart_cycle", 64'(cyc_o[0]), 64'd1);
        issue(1'b1, HALT, 32'h44);
        for (int k = 0; k < 3; k++) issue(1'b0, 32'h0, 32'h0);
        wait_drain("t6_drain", 3);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
